// File: rtl/intra_fdct4x4.sv
// intra_fdct4x4 - forward 4x4 H.264 integer core transform.
//
// Takes one 4x4 luma residual block plus its intra mode, runs the core
// transform as a row pass (one row per cycle) into an intermediate buffer,
// then a column pass (one column per cycle) into the coefficient registers.
// The result is presented under a valid/ready handshake. Only one block is
// buffered at a time, so a new block is accepted only after the previous
// one has been handed off.
//
// Optional feature macro: FDCT_CBF_EN adds the coded-block flag port 'cbf'.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   in_valid   residual block and mode present
//   in_ready   block can be accepted (high only in IDLE)
//   res        16 signed residuals, index 4*row+col, 0 = top-left
//   mode_in    intra 4x4 mode chosen for the block
//   out_valid  coefficients present (high only in DONE)
//   out_ready  consumer takes coefficients
//   coef       16 signed coefficients, index 4*v+u, 0 = DC
//   mode_out   mode_in captured with the block
//   cbf        coded-block flag, any coefficient nonzero (FDCT_CBF_EN only)

module intra_fdct4x4 #(
  parameter int IN_W  = 8,
  parameter int MID_W = 12,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  res [16],
  input  logic        [2:0]       mode_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] coef [16],
  output logic        [2:0]       mode_out
`ifdef FDCT_CBF_EN
  ,
  output logic                    cbf
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ROW,
    COL,
    DONE
  } state_t;

  state_t state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic accept;

  logic signed [IN_W-1:0]  in_buf [16];
  logic signed [MID_W-1:0] mid    [16];

  // Both passes are evaluated at OUT_W; the row result is narrowed to MID_W
  // on storage, which is exact because residual magnitudes bound it to 768.
  logic signed [OUT_W-1:0] row_x [4];
  logic signed [OUT_W-1:0] row_y [4];
  logic signed [OUT_W-1:0] col_x [4];
  logic signed [OUT_W-1:0] col_y [4];

  // One-dimensional 4-point core transform; the x2 factors are shifts.
  function automatic void bfly(
    input  logic signed [OUT_W-1:0] x0,
    input  logic signed [OUT_W-1:0] x1,
    input  logic signed [OUT_W-1:0] x2,
    input  logic signed [OUT_W-1:0] x3,
    output logic signed [OUT_W-1:0] y0,
    output logic signed [OUT_W-1:0] y1,
    output logic signed [OUT_W-1:0] y2,
    output logic signed [OUT_W-1:0] y3
  );
    logic signed [OUT_W-1:0] s03, s12, d03, d12;
    s03 = x0 + x3;
    s12 = x1 + x2;
    d03 = x0 - x3;
    d12 = x1 - x2;
    y0  = s03 + s12;
    y1  = (d03 <<< 1) + d12;
    y2  = s03 - s12;
    y3  = d03 - (d12 <<< 1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter wraps naturally from 3 to 0, which is exactly the restart
  // value needed when moving from ROW to COL.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          cnt_nxt   = 2'd0;
          state_nxt = ROW;
        end
      end
      ROW: begin
        cnt_nxt = cnt + 2'd1;
        if (cnt == 2'd3) state_nxt = COL;
      end
      COL: begin
        cnt_nxt = cnt + 2'd1;
        if (cnt == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Row cnt of the input buffer and column cnt of the intermediate buffer
  // are transformed every cycle; the state decides which result is stored.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      row_x[i] = OUT_W'(in_buf[{cnt, 2'(i)}]);
      col_x[i] = OUT_W'(mid[{2'(i), cnt}]);
    end
    bfly(row_x[0], row_x[1], row_x[2], row_x[3],
         row_y[0], row_y[1], row_y[2], row_y[3]);
    bfly(col_x[0], col_x[1], col_x[2], col_x[3],
         col_y[0], col_y[1], col_y[2], col_y[3]);
  end

  // coef is written only on COL edges, so it keeps the last block's values
  // between blocks and stays stable throughout DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        in_buf[i] <= '0;
        mid[i]    <= '0;
        coef[i]   <= '0;
      end
      mode_out <= 3'd0;
    end else begin
      if (accept) begin
        in_buf   <= res;
        mode_out <= mode_in;
      end
      if (state == ROW) begin
        for (int k = 0; k < 4; k++) begin
          mid[{cnt, 2'(k)}] <= MID_W'(row_y[k]);
        end
      end
      if (state == COL) begin
        for (int v = 0; v < 4; v++) begin
          coef[{2'(v), cnt}] <= col_y[v];
        end
      end
    end
  end

`ifdef FDCT_CBF_EN
  logic cbf_any;

  // On the last COL edge columns 0..2 already hold this block's values while
  // column 3 still holds the previous block's, so column 3 is taken from the
  // butterfly output instead of the register.
  always_comb begin
    cbf_any = 1'b0;
    for (int v = 0; v < 4; v++) begin
      for (int u = 0; u < 3; u++) begin
        if (coef[{2'(v), 2'(u)}] != '0) cbf_any = 1'b1;
      end
      if (col_y[v] != '0) cbf_any = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cbf <= 1'b0;
    end else if (state == COL && cnt == 2'd3) begin
      cbf <= cbf_any;
    end
  end
`endif

endmodule

// File: tb/tb_intra_fdct4x4.sv
// tb_intra_fdct4x4 - scoreboard bench for intra_fdct4x4.
//
// The driver pushes a reference result (computed as C * X * C^T with the
// core transform matrix) into a queue at every accept; an independent
// monitor compares the DUT output at each handshake and checks the
// accept-to-valid latency. Directed blocks cover the corner cases,
// followed by random blocks, backpressure and a mid-block reset.

module tb_intra_fdct4x4;

  localparam int  IN_W   = 8;
  localparam int  MID_W  = 12;
  localparam int  OUT_W  = 16;
  localparam time PERIOD = 10;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [IN_W-1:0]  res  [16];
  logic signed [OUT_W-1:0] coef [16];
  logic [2:0] mode_in, mode_out;
`ifdef FDCT_CBF_EN
  logic cbf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         c [16];
    logic [2:0] mode;
    logic       cbf;
    time        t;
  } exp_t;

  exp_t exp_q [$];
  exp_t last_exp;

  always #(PERIOD / 2) clk = ~clk;

  intra_fdct4x4 #(.IN_W(IN_W), .MID_W(MID_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .res       (res),
    .mode_in   (mode_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .coef      (coef),
    .mode_out  (mode_out)
`ifdef FDCT_CBF_EN
    ,
    .cbf       (cbf)
`endif
  );

  // Row k of the core transform matrix.
  function automatic int basis(input int k, input int n);
    case (k)
      0:       return 1;
      1:       return (n == 0) ? 2 : (n == 1) ? 1 : (n == 2) ? -1 : -2;
      2:       return (n == 0 || n == 3) ? 1 : -1;
      default: return (n == 0) ? 1 : (n == 1) ? -2 : (n == 2) ? 2 : -1;
    endcase
  endfunction

  // coef[v][u] = sum over i,j of C[v][i] * X[i][j] * C[u][j]
  function automatic void refModel(input int x [16], output int c [16]);
    for (int v = 0; v < 4; v++) begin
      for (int u = 0; u < 4; u++) begin
        int acc;
        acc = 0;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            acc += basis(v, i) * x[4*i+j] * basis(u, j);
        c[4*v+u] = acc;
      end
    end
  endfunction

  task automatic checkEq(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    for (int i = 0; i < 16; i++)
      checkEq($sformatf("%s coef[%0d]", tag, i), int'(coef[i]), e.c[i]);
    checkEq($sformatf("%s mode_out", tag), int'(mode_out), int'(e.mode));
`ifdef FDCT_CBF_EN
    checkEq($sformatf("%s cbf", tag), int'(cbf), int'(e.cbf));
`endif
  endtask

  // Drives a block, waits (bounded) for in_ready and records the expected
  // result at the accepting edge. waits = negedges spent waiting for in_ready.
  task automatic applyStimulus(input int blk [16], input logic [2:0] mode,
                               output int waits);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 16; i++) res[i] = IN_W'(blk[i]);
    mode_in  = mode;
    in_valid = 1'b1;
    waits    = 0;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout in_ready=0 required=1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    refModel(blk, e.c);
    e.mode = mode;
    e.cbf  = 1'b0;
    for (int i = 0; i < 16; i++) if (e.c[i] != 0) e.cbf = 1'b1;
    e.t = $time;
    exp_q.push_back(e);
    last_exp = e;
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) res[i] = IN_W'($urandom);
    mode_in = 3'($urandom);
  endtask

  // out_ready only changes just after a rising edge, away from the monitor.
  task automatic setReady(input logic v);
    @(posedge clk);
    #1 out_ready = v;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || !in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
  endtask

  // Monitor: latency check on the first cycle of out_valid, full compare
  // on the cycle whose closing edge completes the handshake.
  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output out_valid=1 required=0");
          end else begin
            checkEq("latency", int'($time - exp_q[0].t),
                    int'(8 * PERIOD + PERIOD / 2));
          end
        end
        if (out_valid && out_ready && exp_q.size() != 0) begin
          checkOutput(exp_q.pop_front(), "handshake");
        end
        prev_valid = out_valid;
      end
    end
  end

  initial begin
    int blk [16];
    int w;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mode_in   = 3'd0;
    for (int i = 0; i < 16; i++) res[i] = '0;
    repeat (3) @(negedge clk);

    checkEq("reset in_ready", int'(in_ready), 1);
    checkEq("reset out_valid", int'(out_valid), 0);
    checkEq("reset mode_out", int'(mode_out), 0);
    for (int i = 0; i < 16; i++)
      checkEq($sformatf("reset coef[%0d]", i), int'(coef[i]), 0);
`ifdef FDCT_CBF_EN
    checkEq("reset cbf", int'(cbf), 0);
`endif
    reset = 1'b0;

    $display("[TB] directed blocks");
    for (int i = 0; i < 16; i++) blk[i] = 0;
    applyStimulus(blk, 3'd2, w);
    drain();

    for (int i = 0; i < 16; i++) blk[i] = 1;
    applyStimulus(blk, 3'd1, w);
    drain();

    for (int i = 0; i < 16; i++) blk[i] = 0;
    blk[0] = 1;
    applyStimulus(blk, 3'd3, w);
    drain();

    for (int i = 0; i < 16; i++) blk[i] = -128;
    applyStimulus(blk, 3'd7, w);
    drain();

    for (int i = 0; i < 16; i++)
      blk[i] = ((i / 4) == 0 || (i / 4) == 3) ? 127 : -128;
    applyStimulus(blk, 3'd4, w);
    drain();

    for (int i = 0; i < 16; i++)
      blk[i] = ((i % 4) == 0 || (i % 4) == 3) ? 127 : -128;
    applyStimulus(blk, 3'd0, w);
    drain();

    $display("[TB] random back-to-back blocks");
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 16; i++) blk[i] = int'($urandom_range(255, 0)) - 128;
      applyStimulus(blk, 3'($urandom_range(7, 0)), w);
    end
    drain();

    $display("[TB] backpressure");
    setReady(1'b0);
    for (int i = 0; i < 16; i++) blk[i] = int'($urandom_range(255, 0)) - 128;
    applyStimulus(blk, 3'd5, w);
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkEq("bp out_valid", int'(out_valid), 1);
    for (int i = 0; i < 16; i++) res[i] = IN_W'($urandom);
    mode_in  = 3'd6;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkEq("bp in_ready", int'(in_ready), 0);
      checkEq("bp out_valid_hold", int'(out_valid), 1);
      checkOutput(last_exp, "bp_hold");
    end
    setReady(1'b1);
    for (int i = 0; i < 16; i++) blk[i] = int'($urandom_range(255, 0)) - 128;
    applyStimulus(blk, 3'd6, w);
    checkEq("bp next accept waits", w, 1);
    drain();

    $display("[TB] reset during column pass");
    for (int i = 0; i < 16; i++) blk[i] = 1;
    applyStimulus(blk, 3'd1, w);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkEq("midreset out_valid", int'(out_valid), 0);
    checkEq("midreset in_ready", int'(in_ready), 1);
    checkEq("midreset mode_out", int'(mode_out), 0);
    for (int i = 0; i < 16; i++)
      checkEq($sformatf("midreset coef[%0d]", i), int'(coef[i]), 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) blk[i] = int'($urandom_range(255, 0)) - 128;
    applyStimulus(blk, 3'd2, w);
    drain();

    repeat (3) @(negedge clk);
    checkEq("idle out_valid", int'(out_valid), 0);
    checkEq("pending expectations", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
